// File: rtl/force_acc_drain_if.sv
// Beat stream in, drained group sums out, for the force accumulator.
// Both directions use valid/ready handshakes.
interface force_acc_drain_if #(
    parameter int DATA_WIDTH = 32,
    parameter int PID_WIDTH  = 12,
    parameter int CNT_WIDTH  = 8
);
    logic                  in_valid;
    logic                  in_ready;
    logic [DATA_WIDTH-1:0] in_data;
    logic [PID_WIDTH-1:0]  in_pid;
    logic                  in_last;
    logic                  out_valid;
    logic                  out_ready;
    logic [DATA_WIDTH-1:0] out_data;
    logic [PID_WIDTH-1:0]  out_pid;
    logic [CNT_WIDTH-1:0]  out_cnt;

    modport master (
        output in_valid, in_data, in_pid, in_last, out_ready,
        input  in_ready, out_valid, out_data, out_pid, out_cnt
    );

    modport slave (
        input  in_valid, in_data, in_pid, in_last, out_ready,
        output in_ready, out_valid, out_data, out_pid, out_cnt
    );
endinterface

// File: rtl/force_acc_drain.sv
// Per-particle FP32 force accumulator with drain FIFO.
// Group sums are queued with pid and beat count once the last beat lands.
module force_acc_drain #(
    parameter int DATA_WIDTH = 32,
    parameter int PID_WIDTH  = 12,
    parameter int CNT_WIDTH  = 8,
    parameter int OUT_DEPTH  = 4
) (
    input  logic             clk,
    input  logic             rst,
    force_acc_drain_if.slave bus,
    output logic             err_pid
);
    localparam int AW = $clog2(OUT_DEPTH);
    localparam logic [AW+1:0] DEPTH_L = (AW+2)'(OUT_DEPTH);
    localparam int EW = DATA_WIDTH + PID_WIDTH + CNT_WIDTH;

    typedef enum logic {IDLE, ACC} state_t;

    // FP32 add, round-to-nearest-even, with IEEE zero/denormal/inf/nan rules
    function automatic logic [31:0] fp_add(input logic [31:0] a,
                                           input logic [31:0] b);
        logic [31:0] x, y, res;
        logic [7:0]  ex, ey, d, em1;
        logic [4:0]  dd, lz, lim, sa;
        logic [26:0] mx, my, ys, n;
        logic [53:0] sh;
        logic [27:0] s;
        logic [8:0]  ne;
        logic [30:0] pk;
        logic        up, nan_a, nan_b, inf_a, inf_b;
        nan_a = (&a[30:23]) && (|a[22:0]);
        nan_b = (&b[30:23]) && (|b[22:0]);
        inf_a = (&a[30:23]) && !(|a[22:0]);
        inf_b = (&b[30:23]) && !(|b[22:0]);
        if (a[30:0] >= b[30:0]) begin
            x = a;
            y = b;
        end else begin
            x = b;
            y = a;
        end
        ex = (x[30:23] == 8'd0) ? 8'd1 : x[30:23];
        ey = (y[30:23] == 8'd0) ? 8'd1 : y[30:23];
        mx = {|x[30:23], x[22:0], 3'b000};
        my = {|y[30:23], y[22:0], 3'b000};
        d  = ex - ey;
        dd = (d > 8'd27) ? 5'd27 : d[4:0];
        sh = {my, 27'd0} >> dd;
        ys = {sh[53:28], sh[27] | (|sh[26:0])};
        if (x[31] == y[31]) s = {1'b0, mx} + {1'b0, ys};
        else                s = {1'b0, mx} - {1'b0, ys};
        lz = 5'd27;
        for (int i = 0; i < 27; i++) begin
            if (s[i]) lz = 5'(26 - i);
        end
        if (s[27]) begin
            n  = {s[27:2], s[1] | s[0]};
            ne = {1'b0, ex} + 9'd1;
        end else begin
            em1 = ex - 8'd1;
            lim = (em1 > 8'd27) ? 5'd27 : em1[4:0];
            sa  = (lz < lim) ? lz : lim;
            n   = s[26:0] << sa;
            ne  = {1'b0, ex} - {4'd0, sa};
        end
        // rounding carry ripples into the exponent field on its own
        pk  = {(n[26] ? ne[7:0] : 8'd0), n[25:3]};
        up  = n[2] & (n[1] | n[0] | n[3]);
        res = {x[31], pk + {30'd0, up}};
        if (n[26] && ne >= 9'd255) res = {x[31], 8'hFF, 23'd0};
        if (s == 28'd0) res = {a[31] & b[31], 31'd0};
        if (nan_a || nan_b || (inf_a && inf_b && (a[31] != b[31])))
            res = 32'h7FC00000;
        else if (inf_a)
            res = a;
        else if (inf_b)
            res = b;
        return res;
    endfunction

    state_t                state_q, state_d;
    logic [DATA_WIDTH-1:0] acc_q, acc_d;
    logic [PID_WIDTH-1:0]  pid_q, pid_d;
    logic [CNT_WIDTH-1:0]  cnt_q, cnt_d;
    logic                  pend_q, pend_d;
    logic                  err_q, err_d;
    logic [EW-1:0]         mem_q [OUT_DEPTH];
    logic [EW-1:0]         mem_d [OUT_DEPTH];
    logic [AW-1:0]         wr_q, wr_d, rd_q, rd_d;
    logic [AW:0]           count_q, count_d;

    logic                  accept, pop;
    logic [DATA_WIDTH-1:0] add_b, add_res;
    logic [EW-1:0]         head;

    assign accept  = bus.in_valid && bus.in_ready;
    assign pop     = bus.out_ready && (count_q != '0);
    assign add_b   = (state_q == ACC) ? acc_q : '0;
    assign add_res = fp_add(bus.in_data, add_b);

    // one slot is held back for a sum that is still in the adder register
    assign bus.in_ready = ({1'b0, count_q} + (AW+2)'(pend_q)) < DEPTH_L;

    assign head          = mem_q[rd_q];
    assign bus.out_valid = (count_q != '0);
    assign bus.out_data  = bus.out_valid ? head[EW-1 -: DATA_WIDTH] : '0;
    assign bus.out_pid   = bus.out_valid ? head[CNT_WIDTH +: PID_WIDTH] : '0;
    assign bus.out_cnt   = bus.out_valid ? head[CNT_WIDTH-1:0] : '0;
    assign err_pid       = err_q;

    // group state, accumulator, pid/count capture and pid-mismatch flag
    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        pid_d   = pid_q;
        cnt_d   = cnt_q;
        pend_d  = 1'b0;
        err_d   = err_q;
        if (accept) begin
            acc_d = add_res;
            unique case (state_q)
                IDLE: begin
                    pid_d = bus.in_pid;
                    cnt_d = CNT_WIDTH'(1);
                end
                ACC: begin
                    if (cnt_q != '1) cnt_d = cnt_q + CNT_WIDTH'(1);
                    if (bus.in_pid != pid_q) err_d = 1'b1;
                end
                default: ;
            endcase
            pend_d  = bus.in_last;
            state_d = bus.in_last ? IDLE : ACC;
        end
    end

    // output FIFO: push the finished group, pop on consumer handshake
    always_comb begin
        mem_d   = mem_q;
        wr_d    = wr_q;
        rd_d    = rd_q;
        if (pend_q) begin
            mem_d[wr_q] = {acc_q, pid_q, cnt_q};
            wr_d        = wr_q + AW'(1);
        end
        if (pop) rd_d = rd_q + AW'(1);
        count_d = count_q + (AW+1)'(pend_q) - (AW+1)'(pop);
    end

    // state registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            acc_q   <= '0;
            pid_q   <= '0;
            cnt_q   <= '0;
            pend_q  <= 1'b0;
            err_q   <= 1'b0;
            wr_q    <= '0;
            rd_q    <= '0;
            count_q <= '0;
            for (int i = 0; i < OUT_DEPTH; i++) mem_q[i] <= '0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            pid_q   <= pid_d;
            cnt_q   <= cnt_d;
            pend_q  <= pend_d;
            err_q   <= err_d;
            wr_q    <= wr_d;
            rd_q    <= rd_d;
            count_q <= count_d;
            mem_q   <= mem_d;
        end
    end
endmodule

// File: tb/tb_force_acc_drain.sv
// Bench for force_acc_drain: directed cases then random groups,
// checked against a group-level model using exact quarter-unit sums.
module tb_force_acc_drain;
    logic clk = 1'b0;
    logic rst = 1'b1;
    logic err_pid;

    always #5 clk = ~clk;

    force_acc_drain_if #(.DATA_WIDTH(32), .PID_WIDTH(12), .CNT_WIDTH(8)) bus ();

    force_acc_drain #(
        .DATA_WIDTH(32), .PID_WIDTH(12), .CNT_WIDTH(8), .OUT_DEPTH(4)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus),
        .err_pid(err_pid)
    );

    typedef struct {
        logic [31:0] d;
        logic [11:0] p;
        logic [7:0]  c;
        int          rdy;
    } exp_t;

    int   total = 0;
    int   bad = 0;
    int   ncyc = 0;
    exp_t exp_q[$];
    exp_t got_q[$];
    bit   m_open = 0;
    bit   m_err = 0;
    int   m_sum, m_pid, m_cnt;

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // value q/4 as FP32 bits; exact for |q| < 2^24
    function automatic logic [31:0] q2f(input int q);
        int unsigned m;
        int p;
        if (q == 0) return 32'h0;
        m = (q < 0) ? -q : q;
        p = 0;
        for (int i = 0; i < 31; i++) if (m >= (32'd1 << i)) p = i;
        return {(q < 0), 8'(p + 125), 23'((m << (23 - p)) & 32'h7FFFFF)};
    endfunction

    task automatic cyc(input bit v, input int q, input int pid,
                       input bit last, input bit ordy, output bit a);
        bit   ev;
        exp_t e;
        @(negedge clk);
        bus.in_valid  = v;
        bus.in_data   = q2f(q);
        bus.in_pid    = 12'(pid);
        bus.in_last   = last;
        bus.out_ready = ordy;
        #1;
        ev = (exp_q.size() > 0) && (exp_q[0].rdy <= ncyc);
        chk("in_ready", bus.in_ready, exp_q.size() < 4);
        chk("out_valid", bus.out_valid, ev);
        chk("err_pid", err_pid, m_err);
        if (ev && ordy) begin
            chk("out_data", bus.out_data, exp_q[0].d);
            chk("out_pid", bus.out_pid, exp_q[0].p);
            chk("out_cnt", bus.out_cnt, exp_q[0].c);
            e.d = bus.out_data;
            e.p = bus.out_pid;
            e.c = bus.out_cnt;
            e.rdy = ncyc;
            got_q.push_back(e);
            void'(exp_q.pop_front());
        end else if (!ev) begin
            chk("out_idle", {bus.out_data, bus.out_pid, bus.out_cnt}, 0);
        end
        a = v && bus.in_ready;
        if (a) begin
            if (!m_open) begin
                m_sum = q;
                m_pid = pid;
                m_cnt = 1;
            end else begin
                m_sum += q;
                m_cnt++;
                if (pid != m_pid) m_err = 1;
            end
            if (last) begin
                e.d = q2f(m_sum);
                e.p = 12'(m_pid);
                e.c = 8'((m_cnt > 255) ? 255 : m_cnt);
                e.rdy = ncyc + 2;
                exp_q.push_back(e);
                m_open = 0;
            end else begin
                m_open = 1;
            end
        end
        ncyc++;
    endtask

    // mode 0: out_ready low, 1: high, 2: random
    task automatic send(input int q, input int pid, input bit last,
                        input int mode);
        bit a;
        bit r;
        a = 0;
        for (int t = 0; t < 60; t++) begin
            r = (mode == 2) ? ($urandom_range(0, 3) != 0) : (mode == 1);
            cyc(1, q, pid, last, r, a);
            if (a) return;
        end
        chk("send_timeout", a, 1);
    endtask

    task automatic idle(input int n, input int mode);
        bit a;
        bit r;
        for (int t = 0; t < n; t++) begin
            r = (mode == 2) ? ($urandom_range(0, 1) != 0) : (mode == 1);
            cyc(0, int'($urandom_range(0, 800)) - 400,
                int'($urandom_range(0, 4095)), $urandom_range(0, 1) != 0, r, a);
        end
    endtask

    task automatic drain();
        bit a;
        for (int t = 0; t < 100 && exp_q.size() > 0; t++) cyc(0, 0, 0, 0, 1, a);
        chk("drain_left", exp_q.size(), 0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1;
        bus.in_valid = 0;
        bus.out_ready = 0;
        @(negedge clk);
        rst = 0;
        exp_q.delete();
        m_open = 0;
        m_err = 0;
        #1;
        chk("rst_out_valid", bus.out_valid, 0);
        chk("rst_in_ready", bus.in_ready, 1);
        chk("rst_err", err_pid, 0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog");
    end

    initial begin
        bit a;
        int k, nacc;
        bus.in_valid = 0;
        bus.in_data = 0;
        bus.in_pid = 0;
        bus.in_last = 0;
        bus.out_ready = 0;
        do_reset();

        // 1+2+3 in one group
        got_q.delete();
        send(4, 5, 0, 1);
        send(8, 5, 0, 1);
        send(12, 5, 1, 1);
        drain();
        chk("t1_data", got_q[0].d, 32'h40C00000);
        chk("t1_pid", got_q[0].p, 5);
        chk("t1_cnt", got_q[0].c, 3);

        // back-to-back single-beat groups
        got_q.delete();
        send(2, 1, 1, 1);
        send(-4, 2, 1, 1);
        drain();
        chk("t2_data0", got_q[0].d, 32'h3F000000);
        chk("t2_pid0", got_q[0].p, 1);
        chk("t2_data1", got_q[1].d, 32'hBF800000);
        chk("t2_pid1", got_q[1].p, 2);
        chk("t2_cnt1", got_q[1].c, 1);

        // backpressure: only four results fit
        got_q.delete();
        k = 0;
        nacc = 0;
        for (int c = 0; c < 10; c++) begin
            cyc(1, 4 * (k + 1), 11 + k, 1, 0, a);
            if (a) begin
                k++;
                nacc++;
            end
        end
        chk("bp_accepted", nacc, 4);
        while (k < 5) begin
            send(4 * (k + 1), 11 + k, 1, 1);
            k++;
        end
        drain();
        chk("bp_n", got_q.size(), 5);
        for (int i = 0; i < 5; i++) chk("bp_order", got_q[i].p, 11 + i);

        // pid change inside a group
        got_q.delete();
        send(6, 7, 0, 1);
        send(6, 8, 1, 1);
        drain();
        idle(3, 1);
        chk("t4_data", got_q[0].d, 32'h40400000);
        chk("t4_pid", got_q[0].p, 7);
        chk("t4_err", err_pid, 1);

        // reset with queued results and an open group
        send(4, 20, 1, 0);
        send(8, 21, 1, 0);
        send(4, 22, 0, 0);
        send(4, 22, 0, 0);
        idle(2, 0);
        do_reset();
        got_q.delete();
        send(4, 3, 0, 1);
        send(4, 3, 1, 1);
        drain();
        chk("t5_n", got_q.size(), 1);
        chk("t5_data", got_q[0].d, 32'h40000000);
        chk("t5_cnt", got_q[0].c, 2);

        // beat counter saturation
        got_q.delete();
        for (int i = 0; i < 300; i++) send(0, 9, i == 299, 1);
        drain();
        chk("t6_data", got_q[0].d, 32'h00000000);
        chk("t6_cnt", got_q[0].c, 8'hFF);

        // random groups, gaps and consumer stalls
        for (int g = 0; g < 80; g++) begin
            int n, pid;
            n = $urandom_range(1, 6);
            pid = $urandom_range(0, 4095);
            for (int b = 0; b < n; b++) begin
                int q, p;
                q = int'($urandom_range(0, 800)) - 400;
                p = ($urandom_range(0, 29) == 0) ? ((pid + 1) & 4095) : pid;
                if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 3), 2);
                send(q, p, b == n - 1, 2);
            end
        end
        drain();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/force_acc_drain.md
Name: force_acc_drain

Overview:
Streaming front-end and read-out controller for the single-precision force accumulator in the range-limited force pipeline. It accepts per-particle partial forces grouped by a last flag and sums each group in a 1-cycle-latency FP32 adder whose output register feeds back as one operand. At group end it drains the final sum, particle ID and beat count into an output FIFO with valid/ready handshake. It then restarts accumulation without any dead cycle.

Parameters:
DATA_WIDTH, 32, IEEE-754 single-precision word width (only 32 supported)
PID_WIDTH, 12, particle ID width
CNT_WIDTH, 8, per-group beat counter width
OUT_DEPTH, 4, output FIFO entries (power of 2, >=2)

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
in_valid  in  1  input beat valid
in_ready  out  1  input beat accepted when in_valid&&in_ready
in_data  in  DATA_WIDTH  partial force, FP32
in_pid  in  PID_WIDTH  particle ID of beat
in_last  in  1  final beat of current particle group
out_valid  out  1  FIFO head valid
out_ready  in  1  consumer pops head when out_valid&&out_ready
out_data  out  DATA_WIDTH  accumulated FP32 sum
out_pid  out  PID_WIDTH  particle ID of group (from first beat)
out_cnt  out  CNT_WIDTH  beats in group
err_pid  out  1  sticky: in_pid changed inside an open group

Behaviour:
- Reset: out_valid=0, FIFO count=0, pending=0, state IDLE, acc=0, beat counter=0, err_pid=0. out_data/out_pid/out_cnt=0 while FIFO empty. Reset mid-group or mid-drain discards all partial and queued results.
- Adder: FP32 add, round-to-nearest-even, registered output, latency 1. Operand A = in_data. Operand B = 0 in IDLE, acc in ACC. acc updates only on accepted beats; otherwise it holds.
- States: IDLE (no group open), ACC (group open).
  - IDLE + accepted beat, in_last=0 -> ACC. Capture pid, cnt=1.
  - IDLE + accepted beat, in_last=1 -> IDLE. Single-beat group; pending set.
  - ACC + accepted beat, in_last=0 -> ACC. cnt+1; saturates at all-ones.
  - ACC + accepted beat, in_last=1 -> IDLE. pending set.
- pending: set the cycle after a last beat is accepted, when acc holds the final sum. In that cycle, {acc, group pid, cnt} is pushed into the FIFO and pending clears. A new group's first beat accepted in that same cycle is legal; its operand B is 0, so it never sees the old sum.
- Back-to-back single-beat groups are legal every cycle: pending pushes every cycle.
- in_ready = (count + pending) < OUT_DEPTH. It is registered-state-only and has no combinational path from out_ready. This reserves a FIFO slot for the in-flight sum, so a push never overflows.
- FIFO: simultaneous push and pop leaves count unchanged. A pop on empty is ignored. A push is never blocked (guaranteed by in_ready). out_* show the head entry.
- err_pid: sets when an accepted ACC-state beat has in_pid != captured pid. The beat is still accumulated, and the group keeps its first pid. Cleared only by rst.
- Accumulation ignores NaN/Inf special handling beyond the adder's IEEE behaviour. No exception outputs.

Test Plan:
- Group 0x3F800000, 0x40000000, 0x40400000 (1+2+3), pid=5, last on third beat, out_ready=1 -> one output 0x40C00000, pid=5, cnt=3, out_valid rises 2 cycles after last beat accepted.
- Back-to-back single-beat groups 0x3F000000 (pid 1) then 0xBF800000 (pid 2) on consecutive cycles -> outputs 0x3F000000/1/1 then 0xBF800000/2/1; no leakage of first sum into second.
- out_ready=0, stream 5 single-beat groups -> in_ready drops after 4 accepted (OUT_DEPTH=4). Raise out_ready -> all 5 results emerge in order with no loss or duplication.
- Group 0x3FC00000, 0x3FC00000 with pid 7 then 8, last on second beat -> out_data 0x40400000, out_pid=7, err_pid=1 and stays 1 until rst.
- Assert rst after 2 beats of an open group and with 2 FIFO entries queued -> next cycle out_valid=0, in_ready=1. A following group 1.0+1.0 yields 0x40000000, cnt=2.
- 300 beats of 0x00000000 in one group (CNT_WIDTH=8) -> out_data 0x00000000, out_cnt=0xFF (saturated).
